// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-bank slave.
// FSM states, register word indices and CTRL/STATUS bit positions.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam logic [2:0] IDX_CTRL    = 3'd0;
    localparam logic [2:0] IDX_STATUS  = 3'd1;
    localparam logic [2:0] IDX_FIFO    = 3'd2;
    localparam logic [2:0] IDX_COUNTER = 3'd3;
    localparam logic [2:0] IDX_SCRATCH = 3'd4;
    localparam logic [2:0] IDX_ID      = 3'd5;

    localparam int CTRL_FIFO_EN  = 0;
    localparam int CTRL_CNT_EN   = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_WAIT_LSB = 4;
    localparam int CTRL_WAIT_MSB = 7;

    localparam logic [7:0] CTRL_MASK = 8'hF7;

    localparam int ST_EMPTY = 8;
    localparam int ST_FULL  = 9;
    localparam int ST_OVF   = 16;
    localparam int ST_UDF   = 17;
    localparam int ST_PERR  = 18;

    localparam logic [31:0] ID_DEFAULT = 32'hA5B0_0001;

endpackage

// File: rtl/apb_slv_fifo.sv
// Synchronous FIFO for the register-bank data port.
// Full pushes and empty pops are dropped and reported as one-cycle strobes.
module apb_slv_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == FULL_LVL);
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign ovf     = push && full;
    assign udf     = pop && empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB register-bank slave: CTRL, STATUS, FIFO, COUNTER, SCRATCH, ID.
// Define APB_SLV_WAIT_EN to add the pready port and CTRL.wait_cnt wait states.
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int          SEL_IDX    = 0,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] pr_data,
`ifdef APB_SLV_WAIT_EN
    output logic        pready,
`endif
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    apb_state_e  state_q, state_d;
    logic        sel;
    logic        unused_sel;
    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [7:0]  ctrl_q;
    logic [31:0] cnt_q;
    logic [31:0] scratch_q;
    logic        ovf_q, udf_q, perr_q;
    logic        latch, launch, commit, perr_set;
    logic        ready, acc_err;
    logic [2:0]  idx;
    logic [31:0] status_w;
    logic [31:0] rdata_mux;
    logic [2:0]  w1c;
    logic        wr_commit, rd_commit;
    logic        fifo_push, fifo_pop;
    logic [31:0] fifo_head;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_level;
    logic        fifo_ovf, fifo_udf;

    assign sel        = psel[SEL_IDX];
    assign unused_sel = ^psel;
    assign idx        = addr_q[4:2];

`ifdef APB_SLV_WAIT_EN
    logic [3:0] wait_q;

    assign ready  = (wait_q == 4'd0);
    assign pready = (state_q != ACCESS) || ready;
`else
    assign ready = 1'b1;
`endif

    // During ACCESS the initiator either holds the same transfer or moves on.
    assign acc_err = (sel && penable && (paddr != addr_q || pwrite != write_q))
                   || (!ready && !(sel && penable));

    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        launch   = 1'b0;
        commit   = 1'b0;
        perr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel && penable) begin
                    perr_set = 1'b1;
                end else if (sel) begin
                    state_d = SETUP;
                    latch   = 1'b1;
                end
            end
            SETUP: begin
                if (!sel) begin
                    perr_set = 1'b1;
                    state_d  = IDLE;
                end else if (penable) begin
                    state_d = ACCESS;
                    launch  = 1'b1;
                end else begin
                    latch = 1'b1;
                end
            end
            ACCESS: begin
                if (acc_err) begin
                    perr_set = 1'b1;
                    state_d  = IDLE;
                end else if (ready) begin
                    commit = 1'b1;
                    if (sel && !penable) begin
                        state_d = SETUP;
                        latch   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_commit = commit && write_q;
    assign rd_commit = commit && !write_q;
    assign fifo_push = wr_commit && idx == IDX_FIFO && ctrl_q[CTRL_FIFO_EN];
    assign fifo_pop  = rd_commit && idx == IDX_FIFO;
    assign w1c = (wr_commit && idx == IDX_STATUS) ?
                 wdata_q[ST_PERR:ST_OVF] : 3'b000;

    assign status_w = {13'b0, perr_q, udf_q, ovf_q, 6'b0,
                       fifo_full, fifo_empty, 3'b0, 5'(fifo_level)};

    always_comb begin
        rdata_mux = '0;
        unique case (1'b1)
            idx == IDX_CTRL:    rdata_mux = {24'b0, ctrl_q};
            idx == IDX_STATUS:  rdata_mux = status_w;
            idx == IDX_FIFO:    rdata_mux = fifo_empty ? '0 : fifo_head;
            idx == IDX_COUNTER: rdata_mux = cnt_q;
            idx == IDX_SCRATCH: rdata_mux = scratch_q;
            idx == IDX_ID:      rdata_mux = ID_VALUE;
            default:            rdata_mux = '0;
        endcase
    end

    assign irq = (ovf_q || udf_q || perr_q) && ctrl_q[CTRL_IRQ_EN];

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pr_data   <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                addr_q  <= paddr;
                write_q <= pwrite;
            end
            if (launch) begin
                wdata_q <= pwdata;
            end
            // Read data is fixed for the whole ACCESS phase, zero otherwise.
            if (launch) begin
                pr_data <= write_q ? '0 : rdata_mux;
            end else if (state_d != ACCESS) begin
                pr_data <= '0;
            end
            if (wr_commit && idx == IDX_CTRL) begin
                ctrl_q <= wdata_q[7:0] & CTRL_MASK;
            end
            if (wr_commit && idx == IDX_SCRATCH) begin
                scratch_q <= wdata_q;
            end
            if (ctrl_q[CTRL_CNT_EN]) begin
                cnt_q <= cnt_q + 32'd1;
            end
            ovf_q  <= (ovf_q && !w1c[0]) || fifo_ovf;
            udf_q  <= (udf_q && !w1c[1]) || fifo_udf;
            perr_q <= (perr_q && !w1c[2]) || perr_set;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            wait_q <= '0;
        end else if (latch) begin
            wait_q <= ctrl_q[CTRL_WAIT_MSB:CTRL_WAIT_LSB];
        end else if (state_q == ACCESS && wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
        end
    end
`endif

    apb_slv_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (hclk),
        .rst_n (hresetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wdata_q),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .ovf   (fifo_ovf),
        .udf   (fifo_udf)
    );

endmodule
